// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous RAM between the fetch port
//               and the data port. Data accesses with address bit 31 set are
//               steered to a separate IO port. Data normally has priority, but
//               a starvation counter forces a fetch grant after STARVE_LIMIT
//               consecutive data wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] IO_NOP       = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    // Fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    // Data port
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // RAM port
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    // IO port
    output logic        io_en,
    output logic [3:0]  io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    // Response source encoding
    localparam logic [2:0] c_src_none     = 3'd0;
    localparam logic [2:0] c_src_i_mem    = 3'd1;
    localparam logic [2:0] c_src_i_err    = 3'd2;
    localparam logic [2:0] c_src_d_mem_rd = 3'd3;
    localparam logic [2:0] c_src_d_io_rd  = 3'd4;
    localparam logic [2:0] c_src_d_wr     = 3'd5;

    logic [3:0] r_streak;
    logic [2:0] r_src;
    logic [2:0] w_src_next;
    logic       w_i_gnt;
    logic       w_d_gnt;

    // Grant: data wins unless fetch has been starved for STARVE_LIMIT wins;
    // gating with reset keeps every grant low while reset is asserted.
    always_comb begin
        w_d_gnt = reset & d_req & ~(i_req & (r_streak == c_limit));
        w_i_gnt = reset & i_req & ~w_d_gnt;
    end

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    // Route the granted request to the RAM or IO port; idle ports read as 0
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        io_en     = 1'b0;
        io_we     = 4'd0;
        io_addr   = 32'd0;
        io_wdata  = 32'd0;
        if (w_i_gnt && !i_addr[31]) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            if (d_addr[31]) begin
                io_en    = 1'b1;
                io_we    = d_we;
                io_addr  = d_addr;
                io_wdata = d_wdata;
            end else begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
        end
    end

    // Classify the granted access so next cycle knows where its data comes from
    always_comb begin
        w_src_next = c_src_none;
        if (w_i_gnt) begin
            w_src_next = i_addr[31] ? c_src_i_err : c_src_i_mem;
        end else if (w_d_gnt) begin
            if (d_we != 4'd0) begin
                w_src_next = c_src_d_wr;
            end else begin
                w_src_next = d_addr[31] ? c_src_d_io_rd : c_src_d_mem_rd;
            end
        end
    end

    // Response source and starvation streak registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src    <= c_src_none;
            r_streak <= 4'd0;
        end else begin
            r_src <= w_src_next;
            if (w_i_gnt || !i_req) begin
                r_streak <= 4'd0;
            end else if (w_d_gnt && r_streak != c_limit) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

    // Drive responses from the registered source, one cycle after grant
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'd0;
        i_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = 32'd0;
        case (r_src)
            c_src_i_mem: begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end
            c_src_i_err: begin
                i_rvalid = 1'b1;
                i_err    = 1'b1;
                i_rdata  = IO_NOP;
            end
            c_src_d_mem_rd: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            c_src_d_io_rd: begin
                d_rvalid = 1'b1;
                d_rdata  = io_rdata;
            end
            c_src_d_wr: begin
                d_rvalid = 1'b1;
            end
            default: begin
                i_rvalid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a small
//               byte-writable RAM model (1-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        io_en;
    logic [3:0]  io_we;
    logic [31:0] io_addr, io_wdata, io_rdata;

    // RAM model with a preload port used only while the DUT is in reset
    logic [31:0] ram [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .IO_NOP(32'h00000013)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata)
    );

    // Synchronous RAM: read-before-write, per-byte write enables
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_data;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100;
        d_we = 4'd0; d_addr = 32'h200; d_wdata = 32'd0; io_rdata = 32'h1234;
        pl_en = 1'b0; pl_idx = 10'd0; pl_data = 32'd0;
        #2;
        chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_io_en", {31'd0, io_en}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_i_err", {31'd0, i_err}, 32'd0);

        preload(10'h040, 32'h00500093);   // 0x100
        preload(10'h080, 32'hDEADBEEF);   // 0x200
        preload(10'h0C0, 32'h11223344);   // 0x300
        chk("rst_hold_rvalid", {31'd0, i_rvalid | d_rvalid}, 32'd0);

        // Release reset, fetch only
        reset = 1'b1; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h100;
        #1;
        chk("fetch_gnt", {31'd0, i_gnt}, 32'd1);
        chk("fetch_mem_en", {31'd0, mem_en}, 32'd1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_we", {28'd0, mem_we}, 32'd0);
        step(); i_req = 1'b0; #1;
        chk("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("fetch_rdata", i_rdata, 32'h00500093);
        chk("fetch_err", {31'd0, i_err}, 32'd0);
        step();
        chk("idle_i_rvalid", {31'd0, i_rvalid}, 32'd0);

        // Conflict: four data grants then one fetch, repeating
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 4'd0; d_addr = 32'h200;
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
            exp_d = ((k % 5) != 4);
            #1;
            chk("conf_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
            chk("conf_i_gnt", {31'd0, i_gnt}, {31'd0, ~exp_d});
            step();
            chk("conf_d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d});
            chk("conf_i_rvalid", {31'd0, i_rvalid}, {31'd0, ~exp_d});
            chk("conf_rdata", exp_d ? d_rdata : i_rdata, exp_d ? 32'hDEADBEEF : 32'h00500093);
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Partial store to RAM, then read back
        d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h300; d_wdata = 32'hAABBCCDD;
        #1;
        chk("st_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("st_mem_en", {31'd0, mem_en}, 32'd1);
        chk("st_mem_we", {28'd0, mem_we}, 32'h3);
        chk("st_mem_addr", mem_addr, 32'h300);
        chk("st_mem_wdata", mem_wdata, 32'hAABBCCDD);
        chk("st_io_en", {31'd0, io_en}, 32'd0);
        step(); d_we = 4'd0;
        chk("st_ack_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("st_ack_rdata", d_rdata, 32'd0);
        #1;
        chk("rb_d_gnt", {31'd0, d_gnt}, 32'd1);
        step();
        chk("rb_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rb_rdata", d_rdata, 32'h1122CCDD);

        // IO store and IO read
        d_we = 4'b0001; d_addr = 32'h80004000; d_wdata = 32'h41;
        #1;
        chk("io_st_io_en", {31'd0, io_en}, 32'd1);
        chk("io_st_io_we", {28'd0, io_we}, 32'h1);
        chk("io_st_io_addr", io_addr, 32'h80004000);
        chk("io_st_io_wdata", io_wdata, 32'h41);
        chk("io_st_mem_en", {31'd0, mem_en}, 32'd0);
        step(); d_we = 4'd0; d_addr = 32'h80006000;
        chk("io_st_ack", {31'd0, d_rvalid}, 32'd1);
        chk("io_st_rdata", d_rdata, 32'd0);
        #1;
        chk("io_rd_io_en", {31'd0, io_en}, 32'd1);
        chk("io_rd_io_we", {28'd0, io_we}, 32'd0);
        step(); d_req = 1'b0;
        chk("io_rd_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("io_rd_rdata", d_rdata, 32'h1234);
        step();

        // Fetch to IO region returns the NOP with an error flag
        i_req = 1'b1; i_addr = 32'h80000000;
        #1;
        chk("fio_gnt", {31'd0, i_gnt}, 32'd1);
        chk("fio_mem_en", {31'd0, mem_en}, 32'd0);
        chk("fio_io_en", {31'd0, io_en}, 32'd0);
        step(); i_req = 1'b0;
        chk("fio_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("fio_err", {31'd0, i_err}, 32'd1);
        chk("fio_rdata", i_rdata, 32'h00000013);
        step();
        chk("fio_err_clr", {31'd0, i_err}, 32'd0);

        // Build up a streak of 2, then reset during a granted data read
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
        step(); step();
        #1;
        chk("mid_d_gnt", {31'd0, d_gnt}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_gnt_forced", {31'd0, d_gnt | i_gnt}, 32'd0);
        chk("mid_rvalid_drop", {31'd0, d_rvalid}, 32'd0);
        step();
        chk("mid_no_resp", {31'd0, d_rvalid | i_rvalid}, 32'd0);
        reset = 1'b1;
        // Streak must restart at zero: four data wins before fetch
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("post_d_gnt", {31'd0, d_gnt}, {31'd0, k != 4});
            chk("post_i_gnt", {31'd0, i_gnt}, {31'd0, k == 4});
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port RAM (1-cycle read latency) between the core's instruction-fetch port and data load/store port.
- Routes data accesses with address bit 31 set (memory-mapped region: 0x80000000 end-of-sim, 0x80001000/0x80004000 char out, 0x80006000 timer) to a separate IO port.
- Sits between the PUCRS_RV core and RAM_mem/peripherals.
- Fixed-priority arbitration with a starvation limit so fetch always progresses.

Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while i_req is pending before fetch is forced a grant (range 1..15).
- IO_NOP, 32'h00000013, instruction word returned for a fetch to the IO region.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  32  fetched word
- i_err  out  1  with i_rvalid: fetch targeted the IO region
- d_req  in  1  data request
- d_we  in  4  byte write enables; 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (load data or store ack)
- d_rdata  out  32  load data; 0 on store ack
- mem_en  out  1  RAM access strobe
- mem_we  out  4  RAM byte enables
- mem_addr  out  32  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en
- io_en, io_we[4], io_addr[32], io_wdata[32]  out  IO-port equivalents of the mem_* outputs
- io_rdata  in  32  IO read data, valid the cycle after io_en

Behaviour:
- Reset (reset=0, async): i_rvalid, d_rvalid, i_err = 0.
  - streak counter = 0; response source = NONE.
  - All gnt/en/we outputs forced 0 while reset is low.
  - Any in-flight response is dropped and never delivered.
- Grant (combinational, same cycle as request):
  - One requester only: it is granted.
  - Both request: d wins unless streak == STARVE_LIMIT, in which case i wins.
  - At most one grant per cycle; back-to-back grants every cycle are allowed.
- Streak counter (4 bits):
  - Increments when d is granted while i_req = 1.
  - Clears when i is granted or i_req = 0.
  - Saturates at STARVE_LIMIT.
- Routing in the grant cycle:
  - i granted, i_addr[31]=0: mem_en=1, mem_we=0, mem_addr=i_addr.
  - i granted, i_addr[31]=1: neither port touched.
  - d granted, d_addr[31]=0: mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
  - d granted, d_addr[31]=1: same on io_* instead.
  - Ungranted port: en=0, we=0, addr=0, wdata=0.
- Response source register, set at the grant edge to one of NONE, I_MEM, I_ERR, D_MEM_RD, D_IO_RD, D_WR.
- Response (exactly 1 cycle after grant), driven from the registered source:
  - I_MEM: i_rvalid=1, i_rdata=mem_rdata.
  - I_ERR: i_rvalid=1, i_err=1, i_rdata=IO_NOP.
  - D_MEM_RD: d_rvalid=1, d_rdata=mem_rdata.
  - D_IO_RD: d_rvalid=1, d_rdata=io_rdata.
  - D_WR: d_rvalid=1, d_rdata=0.
  - Otherwise rvalid=0 and rdata=0.
- Requesters hold req/addr/we/wdata stable until gnt. Changing them before gnt is allowed and simply changes the request.
- Simultaneous events: a response for cycle N and a grant in cycle N+1 coexist; no bubble.
- Reset deasserting mid-request: a request is first eligible at the first rising edge after reset goes high.

Test Plan:
- Reset: reset=0 with i_req=d_req=1 → all gnt/en/rvalid=0. Release reset, i_req=1 only, i_addr=0x100, RAM[0x100]=0x00500093 → i_gnt cycle 0; i_rvalid=1, i_rdata=0x00500093 at cycle 1.
- Conflict and starvation: i_req and d_req (read 0x200) held high continuously → d granted 4 consecutive cycles, then i granted on the 5th, then pattern repeats. i_rvalid never absent for more than 5 cycles.
- Store routing: d_we=4'b0011, d_addr=0x300, d_wdata=0xAABBCCDD → mem_we=0011, mem_wdata=0xAABBCCDD; d_rvalid=1, d_rdata=0 next cycle. Subsequent read of 0x300 returns 0x....CCDD.
- IO path: d_we=0001, d_addr=0x80004000, d_wdata=0x41 → io_en=1, io_we=0001, mem_en=0. Then read 0x80006000 with io_rdata=0x1234 → d_rdata=0x1234 one cycle later.
- Fetch to IO: i_addr=0x80000000 → no mem_en/io_en; i_rvalid=1, i_err=1, i_rdata=0x00000013.
- Reset mid-flight: grant d read, assert reset=0 before next edge → d_rvalid stays 0, streak=0. After release, first grant behaves as after power-on.
